// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the game flow controller.
//   - state_e    : 3-bit FSM state encoding, also exported on state_o
//   - LIVES_W    : lives counter width
//   - LEVEL_W    : level index width
//   - DEF_*      : default timing / lives constants used as top parameters
package game_ctrl_pkg;

  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 2;

  localparam int DEF_START_LIVES = 3;
  localparam int DEF_DIE_FRAMES  = 60;
  localparam int DEF_DONE_FRAMES = 90;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    DYING      = 3'd2,
    RESPAWN    = 3'd3,
    LEVEL_DONE = 3'd4,
    GAME_OVER  = 3'd5,
    PAUSED     = 3'd6
  } state_e;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle between the VGA timing/collision side, the physics block and the
// game flow controller.
//   master : drives frame_start, buttons, collision levels, landing pulse;
//            observes tick/freeze/respawn and game status
//   slave  : the controller (game_flow_ctrl)
// Parameter SCORE_W sets the score bus width.
interface game_flow_ctrl_if #(
  parameter int SCORE_W = 16
);
  import game_ctrl_pkg::*;

  logic               frame_start;
  logic               start_btn;
  logic               pause_btn;
  logic               hazard_hit;
  logic               goal_reached;
  logic               jump_landed_pulse;
  logic               game_tick;
  logic               freeze;
  logic               phys_rst_n;
  logic [2:0]         state_o;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;
  logic [SCORE_W-1:0] score;

  modport master (
    output frame_start, start_btn, pause_btn, hazard_hit, goal_reached,
           jump_landed_pulse,
    input  game_tick, freeze, phys_rst_n, state_o, lives, level, score
  );

  modport slave (
    input  frame_start, start_btn, pause_btn, hazard_hit, goal_reached,
           jump_landed_pulse,
    output game_tick, freeze, phys_rst_n, state_o, lives, level, score
  );

endinterface

// File: rtl/game_flow_ctrl_frame_timer.sv
// Frame counter shared by the DYING and LEVEL_DONE phases.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : zero the count (state entry)
//   frame_start  : one count per video frame
//   limit[6:0]   : terminal frame count
//   done         : 1 while count >= limit
// The count saturates at 127 so a long stay cannot wrap back below limit.
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       frame_start,
  input  logic [6:0] limit,
  output logic       done
);

  logic [6:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (frame_start && (count_q != 7'h7f)) begin
      count_q <= count_q + 7'd1;
    end
  end

  assign done = (count_q >= limit);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer sitting between VGA timing/collision logic and physics.
//   clk, rst : clock, synchronous active-high reset
//   bus      : game_flow_ctrl_if.slave (frame strobe, buttons, collisions,
//              landing pulse in; game_tick, freeze, phys_rst_n, state_o,
//              lives, level, score out)
// Optional feature macro: GAME_PAUSE_EN (pause button toggles PLAY/PAUSED).
//
// state      | meaning
// IDLE       | waiting for start press
// PLAY       | physics running, collisions and landings evaluated
// DYING      | death animation, counts DIE_FRAMES frames
// RESPAWN    | one-cycle physics reset, then PLAY
// LEVEL_DONE | level-complete pause, counts DONE_FRAMES frames
// GAME_OVER  | status held until start press
// PAUSED     | motion frozen (GAME_PAUSE_EN only)
module game_flow_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int START_LIVES = DEF_START_LIVES,
  parameter int NUM_LEVELS  = 4,
  parameter int DIE_FRAMES  = DEF_DIE_FRAMES,
  parameter int DONE_FRAMES = DEF_DONE_FRAMES,
  parameter int SCORE_W     = 16
) (
  input logic             clk,
  input logic             rst,
  game_flow_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               game_tick_q, freeze_q, phys_rst_n_q, start_prev_q;
  logic               start_edge, timer_clear, timer_done;
  logic [6:0]         timer_limit;

  assign start_edge = bus.start_btn & ~start_prev_q;

`ifdef GAME_PAUSE_EN
  logic pause_prev_q, pause_edge;

  always_ff @(posedge clk) begin
    if (rst) pause_prev_q <= 1'b0;
    else     pause_prev_q <= bus.pause_btn;
  end

  assign pause_edge = bus.pause_btn & ~pause_prev_q;
`else
  logic unused_pause;
  assign unused_pause = bus.pause_btn;
`endif

  // Any state change restarts the shared frame count.
  assign timer_clear = (state_d != state_q);
  assign timer_limit = (state_q == DYING) ? 7'(DIE_FRAMES) : 7'(DONE_FRAMES);

  frame_timer u_frame_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (timer_clear),
    .frame_start (bus.frame_start),
    .limit       (timer_limit),
    .done        (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lives_q      <= LIVES_W'(START_LIVES);
      level_q      <= '0;
      score_q      <= '0;
      game_tick_q  <= 1'b0;
      freeze_q     <= 1'b1;
      phys_rst_n_q <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      score_q      <= score_d;
      game_tick_q  <= bus.frame_start;
      // Registered from the next state so they line up with state_q.
      freeze_q     <= (state_d != PLAY);
      phys_rst_n_q <= (state_d != RESPAWN);
      start_prev_q <= bus.start_btn;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    score_d = score_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          lives_d = LIVES_W'(START_LIVES);
          level_d = '0;
          score_d = '0;
          state_d = RESPAWN;
        end
      end
      PLAY: begin
        if (bus.jump_landed_pulse && (score_q != '1)) score_d = score_q + 1'b1;
        // Hazard takes priority over goal when both overlap.
        if (bus.hazard_hit) begin
          lives_d = lives_q - 1'b1;
          state_d = DYING;
        end else if (bus.goal_reached) begin
          state_d = LEVEL_DONE;
        end
`ifdef GAME_PAUSE_EN
        else if (pause_edge) begin
          state_d = PAUSED;
        end
`endif
      end
      DYING: begin
        if (timer_done) state_d = (lives_q == '0) ? GAME_OVER : RESPAWN;
      end
      RESPAWN: state_d = PLAY;
      LEVEL_DONE: begin
        if (timer_done) begin
          level_d = (level_q == LEVEL_W'(NUM_LEVELS - 1)) ? '0 : level_q + 1'b1;
          state_d = RESPAWN;
        end
      end
      GAME_OVER: begin
        if (start_edge) state_d = IDLE;
      end
`ifdef GAME_PAUSE_EN
      PAUSED: begin
        if (pause_edge) state_d = PLAY;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.game_tick  = game_tick_q;
  assign bus.freeze     = freeze_q;
  assign bus.phys_rst_n = phys_rst_n_q;
  assign bus.state_o    = state_q;
  assign bus.lives      = lives_q;
  assign bus.level      = level_q;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed phases with randomized
// frame spacing and landing pulses, checked every cycle against a
// behavioural model of the game rules plus directed checkpoints.
module tb_game_flow_ctrl;

  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_DYING = 2, ST_RESPAWN = 3;
  localparam int ST_DONE = 4, ST_OVER = 5, ST_PAUSED = 6;
  localparam int LIVES0 = 3, NLEV = 4, DIE_N = 60, DONE_N = 90, SCORE_MAX = 65535;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_flow_ctrl_if #(.SCORE_W(16)) bus ();

  game_flow_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_state = ST_IDLE, m_lives = LIVES0, m_level = 0, m_score = 0, m_frames = 0;
  bit m_tick = 0, m_freeze = 1, m_prst = 0, m_sprev = 0, m_pprev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit se, pe;
    int nxt;
    se = bus.start_btn && !m_sprev;
    pe = bus.pause_btn && !m_pprev;
    m_sprev = bus.start_btn;
    m_pprev = bus.pause_btn;
    m_tick  = bus.frame_start;
    if (rst) begin
      m_state = ST_IDLE; m_lives = LIVES0; m_level = 0; m_score = 0; m_frames = 0;
      m_tick = 0; m_freeze = 1; m_prst = 0; m_sprev = 0; m_pprev = 0;
      return;
    end
    nxt = m_state;
    case (m_state)
      ST_IDLE: if (se) begin m_lives = LIVES0; m_level = 0; m_score = 0; nxt = ST_RESPAWN; end
      ST_PLAY: begin
        if (bus.jump_landed_pulse && m_score < SCORE_MAX) m_score++;
        if (bus.hazard_hit) begin nxt = ST_DYING; m_lives--; end
        else if (bus.goal_reached) nxt = ST_DONE;
        else if (PAUSE_EN && pe) nxt = ST_PAUSED;
      end
      ST_DYING:   if (m_frames >= DIE_N) nxt = (m_lives == 0) ? ST_OVER : ST_RESPAWN;
      ST_RESPAWN: nxt = ST_PLAY;
      ST_DONE:    if (m_frames >= DONE_N) begin m_level = (m_level + 1) % NLEV; nxt = ST_RESPAWN; end
      ST_OVER:    if (se) nxt = ST_IDLE;
      ST_PAUSED:  if (pe) nxt = ST_PLAY;
      default:    nxt = ST_IDLE;
    endcase
    if (nxt != m_state) m_frames = 0;
    else if (bus.frame_start) m_frames++;
    m_state  = nxt;
    m_freeze = (nxt != ST_PLAY);
    m_prst   = (nxt != ST_RESPAWN);
  endtask

  function automatic logic [26:0] dut_vec();
    return {bus.state_o, bus.lives, bus.level, bus.score, bus.game_tick, bus.freeze, bus.phys_rst_n};
  endfunction

  function automatic logic [26:0] model_vec();
    return {3'(m_state), 3'(m_lives), 2'(m_level), 16'(m_score), m_tick, m_freeze, m_prst};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("outputs_vs_model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  // n frame pulses with random spacing and random landing pulses
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.jump_landed_pulse = ($urandom_range(0, 3) == 0);
        cycle();
      end
      bus.jump_landed_pulse = ($urandom_range(0, 3) == 0);
      bus.frame_start = 1'b1;
      cycle();
      bus.frame_start = 1'b0;
      bus.jump_landed_pulse = 1'b0;
    end
  endtask

  task automatic pulse_start();
    bus.start_btn = 1'b1; cycle(); bus.start_btn = 1'b0;
  endtask

  task automatic pulse_hazard();
    bus.hazard_hit = 1'b1; cycle(); bus.hazard_hit = 1'b0;
  endtask

  task automatic pulse_goal();
    bus.goal_reached = 1'b1; cycle(); bus.goal_reached = 1'b0;
  endtask

  task automatic random_landings();
    repeat ($urandom_range(1, 6)) begin
      bus.jump_landed_pulse = 1'b1; cycle();
      bus.jump_landed_pulse = 1'b0; repeat ($urandom_range(0, 2)) cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int score_before;
    bus.frame_start = 0; bus.start_btn = 0; bus.pause_btn = 0;
    bus.hazard_hit = 0; bus.goal_reached = 0; bus.jump_landed_pulse = 0;

    // reset
    rst = 1'b1;
    repeat (3) cycle();
    chk("rst_state", 32'(bus.state_o), ST_IDLE);
    chk("rst_lives", 32'(bus.lives), 3);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_freeze", 32'(bus.freeze), 1);
    chk("rst_phys_rst_n", 32'(bus.phys_rst_n), 0);
    rst = 1'b0;
    cycle();
    chk("idle_phys_rst_n", 32'(bus.phys_rst_n), 1);

    // T1: start held for three cycles fires once
    bus.start_btn = 1'b1;
    cycle();
    chk("t1_respawn", 32'(bus.state_o), ST_RESPAWN);
    chk("t1_phys_rst_n", 32'(bus.phys_rst_n), 0);
    cycle();
    chk("t1_play", 32'(bus.state_o), ST_PLAY);
    chk("t1_freeze", 32'(bus.freeze), 0);
    chk("t1_lives", 32'(bus.lives), 3);
    chk("t1_level", 32'(bus.level), 0);
    cycle();
    bus.start_btn = 1'b0;
    chk("t1_held_start", 32'(bus.state_o), ST_PLAY);

    // T2: tick latency and landing count
    bus.frame_start = 1'b1; cycle(); bus.frame_start = 1'b0;
    chk("t2_tick_hi", 32'(bus.game_tick), 1);
    cycle();
    chk("t2_tick_lo", 32'(bus.game_tick), 0);
    repeat (3) begin
      bus.jump_landed_pulse = 1'b1; cycle(); bus.jump_landed_pulse = 1'b0; cycle();
    end
    chk("t2_score3", 32'(bus.score), 3);
    random_landings();

    // T3: hazard and goal together -> death wins
    bus.hazard_hit = 1'b1; bus.goal_reached = 1'b1; cycle();
    bus.hazard_hit = 1'b0; bus.goal_reached = 1'b0;
    chk("t3_dying", 32'(bus.state_o), ST_DYING);
    chk("t3_lives", 32'(bus.lives), 2);
    frames(DIE_N - 1);
    cycle();
    chk("t3_still_dying", 32'(bus.state_o), ST_DYING);
    frames(1);
    cycle();
    chk("t3_respawn", 32'(bus.state_o), ST_RESPAWN);
    cycle();
    chk("t3_play", 32'(bus.state_o), ST_PLAY);

    // T4: remaining deaths -> game over
    random_landings();
    pulse_hazard(); frames(DIE_N); cycle(); cycle();
    chk("t4_lives1", 32'(bus.lives), 1);
    pulse_hazard(); frames(DIE_N); cycle();
    chk("t4_game_over", 32'(bus.state_o), ST_OVER);
    chk("t4_freeze", 32'(bus.freeze), 1);
    chk("t4_lives0", 32'(bus.lives), 0);
    bus.start_btn = 1'b1; cycle();
    chk("t4_idle", 32'(bus.state_o), ST_IDLE);
    cycle(); bus.start_btn = 1'b0;
    chk("t4_held_idle", 32'(bus.state_o), ST_IDLE);
    cycle();

    // T5: level progression and wrap
    pulse_start(); cycle();
    for (int lv = 0; lv < NLEV; lv++) begin
      random_landings();
      score_before = int'(bus.score);
      pulse_goal();
      chk("t5_level_done", 32'(bus.state_o), ST_DONE);
      frames(DONE_N - 1); cycle();
      chk("t5_still_done", 32'(bus.state_o), ST_DONE);
      frames(1); cycle();
      chk("t5_respawn", 32'(bus.state_o), ST_RESPAWN);
      chk("t5_level", 32'(bus.level), 32'((lv + 1) % NLEV));
      chk("t5_score_kept", 32'(bus.score), 32'(score_before));
      cycle();
    end

    // T6: reset while dying
    random_landings();
    pulse_hazard(); frames(5);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("t6_idle", 32'(bus.state_o), ST_IDLE);
    chk("t6_lives", 32'(bus.lives), 3);
    chk("t6_score", 32'(bus.score), 0);
    cycle();

    // pause behaviour
    pulse_start(); cycle();
    bus.pause_btn = 1'b1; cycle(); bus.pause_btn = 1'b0;
    chk("pause_state", 32'(bus.state_o), PAUSE_EN ? ST_PAUSED : ST_PLAY);
    frames(2);
    random_landings();
    pulse_hazard();
    chk("pause_hazard", 32'(bus.state_o), PAUSE_EN ? ST_PAUSED : ST_DYING);
    bus.pause_btn = 1'b1; cycle(); bus.pause_btn = 1'b0;
    chk("pause_resume", 32'(bus.state_o), PAUSE_EN ? ST_PLAY : ST_DYING);
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
